score_display_mux: RTL
======================

Name: score_display_mux

Overview:
- Parametrised score counter and time-multiplexed 7-segment driver for the game's score panel.
- Holds a DIGITS-wide BCD score. Adds a 0-9 amount on each rising edge of add_cube. Tracks a session high score.
- Scans one digit at a time onto a shared segment bus, with optional leading-zero blanking and a selectable high-score view.

Parameters:
- DIGITS, 4, number of BCD digits and digit-select lines (2..8).
- REFRESH_CNT, 50000, clk cycles each digit stays selected (>=2).

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-high reset
- add_cube  input  1  level request; each rising edge adds add_amt once
- add_amt  input  4  BCD amount to add; values 10-15 treated as 9
- clear_score  input  1  synchronous clear of score and overflow
- show_hi  input  1  1 = display hi_score, 0 = display score
- blank_lz  input  1  1 = blank leading zero digits
- seg_out  output  8  segments {a,b,c,d,e,f,g,dp}, active-low, registered
- sel  output  DIGITS  digit enables, active-low one-cold, registered; bit 0 = units
- score  output  4*DIGITS  current BCD score, digit 0 in [3:0]
- hi_score  output  4*DIGITS  highest score since reset
- overflow  output  1  sticky saturation flag

Behaviour:
- Reset (asynchronous, any time including mid-scan or mid-add):
  - score=0, hi_score=0, overflow=0.
  - Scan counter=0, digit index=0, edge register=0.
  - seg_out=8'hFF, sel=all ones (every digit off).
- Edge detect:
  - add_q registers add_cube each cycle.
  - add_evt = add_cube & ~add_q.
  - A held-high add_cube produces exactly one add. The first sample after reset counts as an edge if add_cube is high.
- Add:
  - On add_evt, add min(add_amt,9) into digit 0 with decimal ripple carry through all DIGITS in one cycle.
  - score updates on the clk edge where add_evt is high.
  - add_amt=0 is legal and leaves score unchanged.
- Saturation:
  - If the true sum exceeds 10^DIGITS-1, score becomes all 9s and overflow sets.
  - overflow stays 1 until clear_score or reset.
  - Further adds while saturated leave score at all 9s.
- clear_score:
  - Next edge: score=0, overflow=0. hi_score is kept.
  - clear_score has priority over a simultaneous add_evt; that add is dropped.
- High score:
  - Each cycle, if score > hi_score (plain binary compare, valid for BCD), hi_score<=score.
  - hi_score therefore lags a score change by one cycle and never decreases except on reset.
- Scan:
  - Counter runs 0..REFRESH_CNT-1 and wraps.
  - On the cycle it equals REFRESH_CNT-1, the digit index advances, wrapping DIGITS-1 -> 0.
- Output register:
  - Every cycle, sel and seg_out are loaded from the current index and the displayed value (hi_score if show_hi, else score). Outputs lag index/value by one cycle.
  - sel drives 0 only on bit[index].
- Segment codes (active-low):
  - 0=03, 1=9F, 2=25, 3=0D, 4=99, 5=49, 6=41, 7=1F, 8=01, 9=09 (hex). dp is always off.
  - Blank = FF. Non-BCD nibbles are unreachable; they map to blank.
- Leading-zero blanking:
  - When blank_lz=1, digit i>0 shows FF if it and every higher digit are 0.
  - Digit 0 is never blanked, so score 0 shows "0".
  - sel still strobes blanked digits.
- Changes take effect on the next scanned output cycle: show_hi or blank_lz toggled mid-scan changes the very next register load. No glitch beyond one cycle.

Test Plan:
1. Reset, then hold all inputs 0 for 4*REFRESH_CNT cycles (REFRESH_CNT=4 in sim) -> sel cycles 1110,1101,1011,0111, each held 4 cycles; seg_out=03 on every digit; with blank_lz=1, digits 1-3 show FF.
2. add_amt=7, pulse add_cube twice (held 3 cycles each) -> score=0x0014 after second edge; hi_score=0x0014 one cycle later; units digit shows 99, tens digit 9F.
3. Preload to 0x9995 via adds, then add_amt=9 -> score=0x9999, overflow=1; another add keeps 0x9999.
4. At score 0x0042 assert clear_score in the same cycle as an add_cube edge -> score=0x0000, overflow=0, hi_score stays 0x0042; show_hi=1 displays 42.
5. add_amt=15 -> treated as 9: score 0x0000 -> 0x0009.
6. Assert reset asynchronously mid-digit with add_cube high -> outputs go FF / all-ones sel immediately. After release, one add occurs: score=add_amt.

Source files
------------

// File: rtl/score_display_mux.sv
// BCD score counter with session high score and a time-multiplexed,
// active-low 7-segment scan driver (one digit selected at a time).
module score_display_mux #(
  parameter int DIGITS      = 4,
  parameter int REFRESH_CNT = 50000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  add_cube,
  input  logic [3:0]            add_amt,
  input  logic                  clear_score,
  input  logic                  show_hi,
  input  logic                  blank_lz,
  output logic [7:0]            seg_out,
  output logic [DIGITS-1:0]     sel,
  output logic [4*DIGITS-1:0]   score,
  output logic [4*DIGITS-1:0]   hi_score,
  output logic                  overflow
);

  localparam int SW    = 4 * DIGITS;
  localparam int CNT_W = $clog2(REFRESH_CNT);
  localparam int IDX_W = $clog2(DIGITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_CNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

  // Decimal ripple add of a clamped 0-9 amount; MSB of the result flags
  // saturation, in which case the sum is forced to all nines.
  function automatic logic [SW:0] bcd_add_sat(input logic [SW-1:0] a,
                                               input logic [3:0]    amt);
    logic [4:0]    d;
    logic [3:0]    c;
    logic [SW-1:0] s;
    c = (amt > 4'd9) ? 4'd9 : amt;
    s = '0;
    for (int i = 0; i < DIGITS; i++) begin
      d = {1'b0, a[4*i +: 4]} + {1'b0, c};
      if (d > 5'd9) begin
        s[4*i +: 4] = 4'(d - 5'd10);
        c           = 4'd1;
      end else begin
        s[4*i +: 4] = d[3:0];
        c           = 4'd0;
      end
    end
    if (c != 4'd0) return {1'b1, {DIGITS{4'h9}}};
    return {1'b0, s};
  endfunction

  function automatic logic [7:0] seg_encode(input logic [3:0] d);
    case (d)
      4'd0:    return 8'h03;
      4'd1:    return 8'h9F;
      4'd2:    return 8'h25;
      4'd3:    return 8'h0D;
      4'd4:    return 8'h99;
      4'd5:    return 8'h49;
      4'd6:    return 8'h41;
      4'd7:    return 8'h1F;
      4'd8:    return 8'h01;
      4'd9:    return 8'h09;
      default: return 8'hFF;
    endcase
  endfunction

  logic             add_q;
  logic             add_evt;
  logic [SW:0]      add_res;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx;

  assign add_evt = add_cube & ~add_q;
  assign add_res = bcd_add_sat(score, add_amt);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) add_q <= 1'b0;
    else       add_q <= add_cube;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      score    <= '0;
      overflow <= 1'b0;
    end else if (clear_score) begin
      score    <= '0;
      overflow <= 1'b0;
    end else if (add_evt) begin
      score <= add_res[SW-1:0];
      if (add_res[SW]) overflow <= 1'b1;
    end
  end

  // Plain binary compare orders packed BCD correctly.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 hi_score <= '0;
    else if (score > hi_score) hi_score <= score;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
      idx <= '0;
    end else if (cnt == CNT_LAST) begin
      cnt <= '0;
      idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Stage p0: select displayed value, pick the scanned digit, decide blanking
  logic [SW-1:0]     disp_val_p0;
  logic [3:0]        digit_p0;
  logic              blank_p0;
  logic              upper_zero;
  logic [DIGITS-1:0] sel_p0;

  always_comb begin
    disp_val_p0 = show_hi ? hi_score : score;
    digit_p0    = disp_val_p0[3:0];
    blank_p0    = 1'b0;
    upper_zero  = 1'b1;
    sel_p0      = '1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero & (disp_val_p0[4*i +: 4] == 4'd0);
      sel_p0[i]  = (idx != IDX_W'(i));
      if (idx == IDX_W'(i)) begin
        digit_p0 = disp_val_p0[4*i +: 4];
        blank_p0 = blank_lz && (i != 0) && upper_zero;
      end
    end
  end

  // Stage p1: registered segment and digit-select outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg_out <= 8'hFF;
      sel     <= '1;
    end else begin
      seg_out <= blank_p0 ? 8'hFF : seg_encode(digit_p0);
      sel     <= sel_p0;
    end
  end

endmodule
